// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback,
// drives datapath selects and enables, counts retired instructions, traps on bad encodings.
module mips_multicycle_ctrl (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        mem_req,
    output logic        mem_we,
    output logic        iord,
    output logic        ir_write,
    output logic        pc_write,
    output logic        reg_write,
    output logic [1:0]  pc_src,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic        imm_zext,
    output logic [2:0]  alu_ctrl,
    output logic [1:0]  reg_dst,
    output logic [1:0]  mem_to_reg,
    output logic        illegal,
    output logic [31:0] instret
);
    localparam int unsigned CNT_W = 32;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_SLL = 6'h00;
    localparam logic [5:0] FN_SRL = 6'h02;
    localparam logic [5:0] FN_JR  = 6'h08;
    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_SLT = 6'h2A;

    localparam logic [2:0] ALU_ADD = 3'd0;
    localparam logic [2:0] ALU_SUB = 3'd1;
    localparam logic [2:0] ALU_AND = 3'd2;
    localparam logic [2:0] ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_SLT = 3'd4;
    localparam logic [2:0] ALU_SLL = 3'd5;
    localparam logic [2:0] ALU_SRL = 3'd6;
    localparam logic [2:0] ALU_LUI = 3'd7;

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_ALU_WB, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WB, S_MEM_WR, S_BRANCH, S_JUMP, S_JAL, S_JR, S_TRAP
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic [CNT_W-1:0]  r_instret;
    logic              w_retire;
    logic              w_r_ok;
    logic [2:0]        w_r_alu;
    logic              w_i_ok;
    logic [2:0]        w_i_alu;
    logic              w_mem_req;
    logic              w_mem_we;
    logic              w_ir_write;
    logic              w_pc_write;
    logic              w_reg_write;
    logic              w_illegal;

    // R-type funct decode (jr handled separately)
    always_comb begin
        w_r_ok  = 1'b1;
        w_r_alu = ALU_ADD;
        case (funct)
            FN_ADD:  w_r_alu = ALU_ADD;
            FN_SUB:  w_r_alu = ALU_SUB;
            FN_AND:  w_r_alu = ALU_AND;
            FN_OR:   w_r_alu = ALU_OR;
            FN_SLT:  w_r_alu = ALU_SLT;
            FN_SLL:  w_r_alu = ALU_SLL;
            FN_SRL:  w_r_alu = ALU_SRL;
            default: w_r_ok  = 1'b0;
        endcase
    end

    // I-type ALU opcode decode
    always_comb begin
        w_i_ok  = 1'b1;
        w_i_alu = ALU_ADD;
        case (opcode)
            OP_ADDI: w_i_alu = ALU_ADD;
            OP_ANDI: w_i_alu = ALU_AND;
            OP_ORI:  w_i_alu = ALU_OR;
            OP_SLTI: w_i_alu = ALU_SLT;
            OP_LUI:  w_i_alu = ALU_LUI;
            default: w_i_ok  = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_FETCH;
            r_instret <= '0;
        end else begin
            r_state <= w_next;
            if (w_retire) r_instret <= r_instret + CNT_W'(1);
        end
    end

    always_comb begin
        w_next      = r_state;
        w_retire    = 1'b0;
        w_mem_req   = 1'b0;
        w_mem_we    = 1'b0;
        iord        = 1'b0;
        w_ir_write  = 1'b0;
        w_pc_write  = 1'b0;
        w_reg_write = 1'b0;
        pc_src      = 2'd0;
        alu_src_a   = 2'd0;
        alu_src_b   = 2'd0;
        imm_zext    = 1'b0;
        alu_ctrl    = ALU_ADD;
        reg_dst     = 2'd0;
        mem_to_reg  = 2'd0;
        w_illegal   = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_b = 2'd1;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end
            end
            S_DECODE: begin
                alu_src_b = 2'd3;
                if (opcode == OP_RTYPE) begin
                    if (funct == FN_JR) w_next = S_JR;
                    else if (w_r_ok)    w_next = S_EXEC_R;
                    else                w_next = S_TRAP;
                end else if (opcode == OP_LW || opcode == OP_SW) begin
                    w_next = S_MEM_ADDR;
                end else if (opcode == OP_BEQ || opcode == OP_BNE) begin
                    w_next = S_BRANCH;
                end else if (w_i_ok) begin
                    w_next = S_EXEC_I;
                end else if (opcode == OP_J) begin
                    w_next = S_JUMP;
                end else if (opcode == OP_JAL) begin
                    w_next = S_JAL;
                end else begin
                    w_next = S_TRAP;
                end
            end
            S_EXEC_R: begin
                alu_src_a = (funct == FN_SLL || funct == FN_SRL) ? 2'd2 : 2'd1;
                alu_ctrl  = w_r_alu;
                w_next    = S_ALU_WB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                imm_zext  = (opcode == OP_ANDI || opcode == OP_ORI);
                alu_ctrl  = w_i_alu;
                w_next    = S_ALU_WB;
            end
            S_ALU_WB: begin
                w_reg_write = 1'b1;
                reg_dst     = (opcode == OP_RTYPE) ? 2'd1 : 2'd0;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_ADDR: begin
                alu_src_a = 2'd1;
                alu_src_b = 2'd2;
                w_next    = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                if (mem_ready) w_next = S_MEM_WB;
            end
            S_MEM_WB: begin
                w_reg_write = 1'b1;
                mem_to_reg  = 2'd1;
                w_retire    = 1'b1;
                w_next      = S_FETCH;
            end
            S_MEM_WR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_retire = 1'b1;
                    w_next   = S_FETCH;
                end
            end
            S_BRANCH: begin
                alu_src_a  = 2'd1;
                alu_ctrl   = ALU_SUB;
                pc_src     = 2'd1;
                w_pc_write = (opcode == OP_BEQ) ? zero : !zero;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_JUMP, S_JAL: begin
                pc_src     = 2'd2;
                w_pc_write = 1'b1;
                if (r_state == S_JAL) begin
                    w_reg_write = 1'b1;
                    reg_dst     = 2'd2;
                    mem_to_reg  = 2'd2;
                end
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            // rs | r0 through the ALU yields the jump register value
            S_JR: begin
                alu_src_a  = 2'd1;
                alu_ctrl   = ALU_OR;
                w_pc_write = 1'b1;
                w_retire   = 1'b1;
                w_next     = S_FETCH;
            end
            S_TRAP: w_illegal = 1'b1;
            default: w_next = S_FETCH;
        endcase
    end

    // Reset masks every side effect regardless of the current state
    assign mem_req   = w_mem_req   & ~rst;
    assign mem_we    = w_mem_we    & ~rst;
    assign ir_write  = w_ir_write  & ~rst;
    assign pc_write  = w_pc_write  & ~rst;
    assign reg_write = w_reg_write & ~rst;
    assign illegal   = w_illegal   & ~rst;
    assign instret   = r_instret;
endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-cycle control vectors and
// retired-instruction count checked against hand-derived values.
module tb_mips_multicycle_ctrl;
    logic        clk = 1'b0;
    logic        rst;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic        zero;
    logic        mem_ready;
    logic        mem_req, mem_we, iord, ir_write, pc_write, reg_write;
    logic [1:0]  pc_src, alu_src_a, alu_src_b, reg_dst, mem_to_reg;
    logic        imm_zext, illegal;
    logic [2:0]  alu_ctrl;
    logic [31:0] instret;
    logic [20:0] ctl;

    int n_cmp = 0;
    int n_err = 0;

    mips_multicycle_ctrl dut (
        .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
        .pc_src(pc_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .imm_zext(imm_zext), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .illegal(illegal), .instret(instret)
    );

    always #5 clk = ~clk;

    assign ctl = {mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src,
                  alu_src_a, alu_src_b, imm_zext, alu_ctrl, reg_dst, mem_to_reg, illegal};

    function automatic logic [20:0] cv(input int unsigned req, we, io, irw, pcw, rw, ps,
                                       sa, sb, zx, alu, rd, m2r, ill);
        return {1'(req), 1'(we), 1'(io), 1'(irw), 1'(pcw), 1'(rw), 2'(ps), 2'(sa),
                2'(sb), 1'(zx), 3'(alu), 2'(rd), 2'(m2r), 1'(ill)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Check the control vector mid-cycle, then advance to just after the next edge
    task automatic cyc(input string tag, input logic [20:0] e);
        #1;
        chk(tag, 32'(ctl), 32'(e));
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [20:0] v_f, v_fs, v_fr, v_d, v_er_add, v_er_sll, v_wb_r, v_wb_i, v_ei_ori;
        logic [20:0] v_ma, v_mr, v_mwb, v_br_t, v_br_n, v_jal, v_jr, v_mw, v_mw_rst;
        logic [20:0] v_j, v_tr;
        v_f      = cv(1,0,0,1,1,0, 0,0,1,0,0,0,0,0);
        v_fs     = cv(1,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        v_fr     = cv(0,0,0,0,0,0, 0,0,1,0,0,0,0,0);
        v_d      = cv(0,0,0,0,0,0, 0,0,3,0,0,0,0,0);
        v_er_add = cv(0,0,0,0,0,0, 0,1,0,0,0,0,0,0);
        v_er_sll = cv(0,0,0,0,0,0, 0,2,0,0,5,0,0,0);
        v_wb_r   = cv(0,0,0,0,0,1, 0,0,0,0,0,1,0,0);
        v_wb_i   = cv(0,0,0,0,0,1, 0,0,0,0,0,0,0,0);
        v_ei_ori = cv(0,0,0,0,0,0, 0,1,2,1,3,0,0,0);
        v_ma     = cv(0,0,0,0,0,0, 0,1,2,0,0,0,0,0);
        v_mr     = cv(1,0,1,0,0,0, 0,0,0,0,0,0,0,0);
        v_mwb    = cv(0,0,0,0,0,1, 0,0,0,0,0,0,1,0);
        v_br_t   = cv(0,0,0,0,1,0, 1,1,0,0,1,0,0,0);
        v_br_n   = cv(0,0,0,0,0,0, 1,1,0,0,1,0,0,0);
        v_jal    = cv(0,0,0,0,1,1, 2,0,0,0,0,2,2,0);
        v_jr     = cv(0,0,0,0,1,0, 0,1,0,0,3,0,0,0);
        v_mw     = cv(1,1,1,0,0,0, 0,0,0,0,0,0,0,0);
        v_mw_rst = cv(0,0,1,0,0,0, 0,0,0,0,0,0,0,0);
        v_j      = cv(0,0,0,0,1,0, 2,0,0,0,0,0,0,0);
        v_tr     = cv(0,0,0,0,0,0, 0,0,0,0,0,0,0,1);

        rst = 1'b1; opcode = 6'h00; funct = 6'h00; zero = 1'b0; mem_ready = 1'b1;
        @(posedge clk); #1; @(posedge clk); #1;
        cyc("rst_fetch_masked", v_fr);
        chk("rst_instret", instret, 32'd0);
        rst = 1'b0;

        // add $3,$1,$2 (0x00221820)
        opcode = 6'h00; funct = 6'h20;
        cyc("add_fetch", v_f);
        cyc("add_decode", v_d);
        cyc("add_exec", v_er_add);
        cyc("add_wb", v_wb_r);
        chk("add_instret", instret, 32'd1);

        // lw with two wait cycles in MEM_RD
        opcode = 6'h23;
        cyc("lw_fetch", v_f);
        cyc("lw_decode", v_d);
        cyc("lw_addr", v_ma);
        mem_ready = 1'b0;
        cyc("lw_rd_wait1", v_mr);
        cyc("lw_rd_wait2", v_mr);
        mem_ready = 1'b1;
        cyc("lw_rd_done", v_mr);
        #1 chk("lw_wb_instret_before", instret, 32'd1);
        cyc("lw_wb", v_mwb);
        chk("lw_instret", instret, 32'd2);

        // beq taken then not taken
        opcode = 6'h04; zero = 1'b1;
        cyc("beq_t_fetch", v_f);
        cyc("beq_t_decode", v_d);
        cyc("beq_t_branch", v_br_t);
        zero = 1'b0;
        cyc("beq_n_fetch", v_f);
        cyc("beq_n_decode", v_d);
        cyc("beq_n_branch", v_br_n);
        chk("beq_instret", instret, 32'd4);

        // jal with one fetch stall
        opcode = 6'h03; mem_ready = 1'b0;
        cyc("jal_fetch_stall", v_fs);
        mem_ready = 1'b1;
        cyc("jal_fetch", v_f);
        cyc("jal_decode", v_d);
        cyc("jal_exec", v_jal);

        // ori, sll, jr
        opcode = 6'h0D;
        cyc("ori_fetch", v_f);
        cyc("ori_decode", v_d);
        cyc("ori_exec", v_ei_ori);
        cyc("ori_wb", v_wb_i);
        opcode = 6'h00; funct = 6'h00;
        cyc("sll_fetch", v_f);
        cyc("sll_decode", v_d);
        cyc("sll_exec", v_er_sll);
        cyc("sll_wb", v_wb_r);
        funct = 6'h08;
        cyc("jr_fetch", v_f);
        cyc("jr_decode", v_d);
        cyc("jr_exec", v_jr);
        chk("jr_instret", instret, 32'd8);

        // sw aborted by reset while in MEM_WR
        opcode = 6'h2B;
        cyc("sw_fetch", v_f);
        cyc("sw_decode", v_d);
        cyc("sw_addr", v_ma);
        mem_ready = 1'b0;
        cyc("sw_wr_wait", v_mw);
        rst = 1'b1; mem_ready = 1'b1;
        #1 chk("sw_rst_instret_before", instret, 32'd8);
        cyc("sw_wr_rst", v_mw_rst);
        rst = 1'b0;
        chk("sw_rst_instret", instret, 32'd0);

        // j, then unsupported opcode traps
        opcode = 6'h02;
        cyc("j_fetch", v_f);
        cyc("j_decode", v_d);
        cyc("j_exec", v_j);
        opcode = 6'h3F;
        cyc("trap_fetch", v_f);
        chk("trap_instret_pre", instret, 32'd1);
        cyc("trap_decode", v_d);
        for (int i = 0; i < 3; i++) begin
            cyc("trap_hold", v_tr);
            chk("trap_instret", instret, 32'd1);
        end
        rst = 1'b1;
        cyc("trap_rst", 21'd0);
        rst = 1'b0;
        chk("trap_rst_instret", instret, 32'd0);

        // unsupported R-type funct also traps
        opcode = 6'h00; funct = 6'h21;
        cyc("badfn_fetch", v_f);
        cyc("badfn_decode", v_d);
        cyc("badfn_trap", v_tr);
        chk("badfn_instret", instret, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle control FSM for the MIPS core. It sequences one instruction at a time through fetch, decode, execute, memory and writeback, using the opcode/funct fields from the instruction decoder. It drives the datapath mux selects, register/memory write enables and the ALU operation, and handshakes with the unified instruction/data memory. It also keeps a retired-instruction counter and traps on unsupported encodings.

## Interface
- No parameters.
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- opcode  in  6  decoded instruction[31:26], valid from DECODE onward
- funct  in  6  decoded instruction[5:0]
- zero  in  1  ALU zero flag (combinational, current cycle)
- mem_ready  in  1  memory completes the request this cycle
- mem_req / mem_we  out  1 / 1  memory request; write when mem_we=1
- iord  out  1  memory address: 0=PC, 1=ALUOut
- ir_write, pc_write, reg_write  out  1 each  load IR, PC, register file
- pc_src  out  2  0=ALU result, 1=ALUOut, 2=jump target {PC[31:28],instr[25:0],2'b00}
- alu_src_a  out  2  0=PC, 1=rs, 2=shamt (zero-extended)
- alu_src_b  out  2  0=rt, 1=const 4, 2=immediate, 3=immediate<<2
- imm_zext  out  1  immediate zero-extended instead of sign-extended
- alu_ctrl  out  3  0=ADD 1=SUB 2=AND 3=OR 4=SLT 5=SLL 6=SRL 7=LUI
- reg_dst  out  2  0=rt, 1=rd, 2=r31
- mem_to_reg  out  2  0=ALUOut, 1=MDR, 2=PC
- illegal  out  1  high while in TRAP
- instret  out  32  retired-instruction count

## Operation
- Supported: R-type (opcode 0) funct add 0x20, sub 0x22, and 0x24, or 0x25, slt 0x2A, sll 0x00, srl 0x02, jr 0x08; lw 0x23, sw 0x2B, beq 0x04, bne 0x05, addi 0x08, andi 0x0C, ori 0x0D, slti 0x0A, lui 0x0F, j 0x02, jal 0x03. Anything else -> TRAP.
- Outputs are combinational from state (plus opcode/funct/zero where noted). Unlisted signals are 0.
- FETCH: mem_req, iord=0, alu_src_a=0, alu_src_b=1, ADD, pc_src=0; ir_write and pc_write only in the cycle mem_ready=1, which also moves to DECODE. Otherwise stay.
- DECODE: alu_src_a=0, alu_src_b=3, ADD (branch target into ALUOut). Next by opcode: R-type->EXEC_R (jr->JR), lw/sw->MEM_ADDR, beq/bne->BRANCH, I-ALU->EXEC_I, j->JUMP, jal->JAL, else TRAP.
- EXEC_R: alu_src_a=2 for sll/srl else 1; alu_src_b=0; alu_ctrl from funct -> ALU_WB.
- EXEC_I: alu_src_a=1, alu_src_b=2, imm_zext for andi/ori; addi ADD, andi AND, ori OR, slti SLT, lui LUI -> ALU_WB.
- ALU_WB: reg_write, mem_to_reg=0, reg_dst=1 if opcode 0 else 0 -> FETCH, retire.
- MEM_ADDR: alu_src_a=1, alu_src_b=2, ADD -> MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req, iord=1; wait for mem_ready -> MEM_WB. MEM_WB: reg_write, mem_to_reg=1, reg_dst=0 -> FETCH, retire.
- MEM_WR: mem_req, mem_we, iord=1; on mem_ready -> FETCH, retire.
- BRANCH: alu_src_a=1, alu_src_b=0, SUB, pc_src=1; pc_write = zero (beq) or !zero (bne) -> FETCH, retire.
- JUMP: pc_src=2, pc_write -> FETCH, retire. JAL: same plus reg_write, reg_dst=2, mem_to_reg=2 (PC already +4). JR: alu_src_a=1, alu_src_b=0... use pc_src=0 with alu_src_a=1, alu_src_b=2 is wrong; JR drives alu_src_a=1, alu_ctrl=OR, alu_src_b=0 with rt=r0 guaranteed by encoding, pc_src=0, pc_write -> FETCH, retire.
- TRAP: illegal=1, all enables 0; held until rst.
- instret increments by 1 on every retiring transition; wraps 0xFFFFFFFF -> 0.

## Timing
- Reset: state FETCH, instret 0, illegal 0. While rst=1 all write enables and mem_req forced 0 regardless of state; reset mid-instruction aborts it without retiring.
- Zero-wait latency: R-type/I-ALU 4 cycles, lw 5, sw 4, beq/bne/j/jal/jr 3. Each mem_ready=0 cycle in FETCH/MEM_RD/MEM_WR adds one cycle.
- mem_req stays high until mem_ready; mem_ready outside a request is ignored.
- instret visible updated the cycle after the retiring state.

## Test plan
- Reset then add (0x00221820), mem_ready always 1 -> states FETCH,DECODE,EXEC_R,ALU_WB; reg_write with reg_dst=1 in cycle 4; instret=1.
- lw with mem_ready low 2 cycles in MEM_RD -> 7 cycles total; reg_write, mem_to_reg=1 once.
- beq with zero=1 vs zero=0 -> pc_write=1/pc_src=1 vs pc_write=0; both retire in 3 cycles.
- jal -> pc_src=2, reg_dst=2, mem_to_reg=2, reg_write in same cycle.
- opcode 0x3F -> illegal=1 from cycle 3, no enables, instret unchanged until rst.
- rst asserted in MEM_WR -> mem_we=0 that cycle, next state FETCH, instret=0.
